// File: rtl/wb_port_arbiter_if.sv
// Writeback arbiter bus: per-lane result handshakes, branch resolution,
// and the registered register-file write ports.
interface wb_port_arbiter_if #(
  parameter int NUM_LANES       = 4,
  parameter int NUM_WR_PORTS    = 2,
  parameter int DATA_W          = 32,
  parameter int TAG_W           = 7,
  parameter int CHECKPOINTS     = 8,
  parameter int CHECKPOINTS_LOG = 3,
  parameter int LANE_W          = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
);
  logic [NUM_LANES-1:0]             lane_valid_i;
  logic [NUM_LANES-1:0]             lane_ready_o;
  logic [NUM_LANES*TAG_W-1:0]       lane_tag_i;
  logic [NUM_LANES*DATA_W-1:0]      lane_data_i;
  logic [NUM_LANES*CHECKPOINTS-1:0] lane_mask_i;
  logic                             ctrlVerified_i;
  logic                             ctrlMispredict_i;
  logic [CHECKPOINTS_LOG-1:0]       ctrlSMTid_i;
  logic [NUM_WR_PORTS-1:0]          wr_valid_o;
  logic [NUM_WR_PORTS*TAG_W-1:0]    wr_tag_o;
  logic [NUM_WR_PORTS*DATA_W-1:0]   wr_data_o;
  logic [NUM_WR_PORTS*LANE_W-1:0]   wr_lane_o;
  logic                             idle_o;

  modport master (
    output lane_valid_i, lane_tag_i, lane_data_i, lane_mask_i,
           ctrlVerified_i, ctrlMispredict_i, ctrlSMTid_i,
    input  lane_ready_o, wr_valid_o, wr_tag_o, wr_data_o, wr_lane_o, idle_o
  );

  modport slave (
    input  lane_valid_i, lane_tag_i, lane_data_i, lane_mask_i,
           ctrlVerified_i, ctrlMispredict_i, ctrlSMTid_i,
    output lane_ready_o, wr_valid_o, wr_tag_o, wr_data_o, wr_lane_o, idle_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: small per-lane result buffers, round-robin granted onto
// the register-file write ports, with branch squash and mask-clear on buffered results.
module wb_lane_buf #(
  parameter int DEPTH           = 2,
  parameter int DATA_W          = 32,
  parameter int TAG_W           = 7,
  parameter int CHECKPOINTS     = 8,
  parameter int CHECKPOINTS_LOG = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pushVld,
  input  logic [TAG_W-1:0]           pushTag,
  input  logic [DATA_W-1:0]          pushData,
  input  logic [CHECKPOINTS-1:0]     pushMask,
  input  logic                       squash,
  input  logic                       maskClr,
  input  logic [CHECKPOINTS_LOG-1:0] brId,
  input  logic                       pop,
  output logic                       ready,
  output logic                       empty,
  output logic                       headVld,
  output logic [TAG_W-1:0]           headTag,
  output logic [DATA_W-1:0]          headData
);
  typedef struct packed {
    logic                   vld;
    logic [CHECKPOINTS-1:0] mask;
    logic [TAG_W-1:0]       tag;
    logic [DATA_W-1:0]      data;
  } ent_t;

  ent_t [DEPTH-1:0]       ent, entNxt;
  logic [DEPTH-1:0]       live, keep;
  logic [CHECKPOINTS-1:0] clrMask;
  logic                   accept, popDone;

  // Valid entries stay compacted toward slot 0 in arrival order, so the top
  // slot alone tells whether the buffer is full.
  assign ready   = ~ent[DEPTH-1].vld;
  assign empty   = ~ent[0].vld;
  assign accept  = pushVld & ready & ~(squash & pushMask[brId]);
  assign clrMask = maskClr ? (CHECKPOINTS'(1) << brId) : '0;

  always_comb begin
    live     = '0;
    keep     = '0;
    popDone  = 1'b0;
    headVld  = 1'b0;
    headTag  = '0;
    headData = '0;
    for (int k = 0; k < DEPTH; k++)
      live[k] = ent[k].vld & ~(squash & ent[k].mask[brId]);
    // Head is the oldest survivor of this cycle's squash.
    for (int k = DEPTH-1; k >= 0; k--)
      if (live[k]) begin
        headVld  = 1'b1;
        headTag  = ent[k].tag;
        headData = ent[k].data;
      end
    for (int k = 0; k < DEPTH; k++) begin
      keep[k] = live[k];
      if (pop && live[k] && !popDone) begin
        keep[k] = 1'b0;
        popDone = 1'b1;
      end
    end
  end

  always_comb begin
    int n;
    n      = 0;
    entNxt = '0;
    for (int k = 0; k < DEPTH; k++)
      if (keep[k]) begin
        for (int j = 0; j < DEPTH; j++)
          if (j == n) begin
            entNxt[j]      = ent[k];
            entNxt[j].mask = ent[k].mask & ~clrMask;
          end
        n++;
      end
    if (accept)
      for (int j = 0; j < DEPTH; j++)
        if (j == n)
          entNxt[j] = '{vld: 1'b1, mask: pushMask & ~clrMask, tag: pushTag, data: pushData};
  end

  always_ff @(posedge clk) begin
    if (!reset) ent <= '0;
    else        ent <= entNxt;
  end
endmodule

module wb_port_arbiter #(
  parameter int NUM_LANES       = 4,
  parameter int NUM_WR_PORTS    = 2,
  parameter int FIFO_DEPTH      = 2,
  parameter int DATA_W          = 32,
  parameter int TAG_W           = 7,
  parameter int CHECKPOINTS     = 8,
  parameter int CHECKPOINTS_LOG = 3,
  parameter int LANE_W          = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  wb_port_arbiter_if.slave bus
);
  logic                               squash, maskClr;
  logic [NUM_LANES-1:0]               ready, empty, headVld, grant;
  logic [NUM_LANES-1:0][TAG_W-1:0]    headTag;
  logic [NUM_LANES-1:0][DATA_W-1:0]   headData;
  logic [NUM_WR_PORTS-1:0]            portVld, wrValid;
  logic [NUM_WR_PORTS-1:0][TAG_W-1:0] portTag, wrTag;
  logic [NUM_WR_PORTS-1:0][DATA_W-1:0] portData, wrData;
  logic [NUM_WR_PORTS-1:0][LANE_W-1:0] portLane, wrLane;
  logic [LANE_W-1:0]                  rr, rrNxt;

  assign squash  = bus.ctrlVerified_i & bus.ctrlMispredict_i;
  assign maskClr = bus.ctrlVerified_i & ~bus.ctrlMispredict_i;

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      wb_lane_buf #(
        .DEPTH(FIFO_DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W),
        .CHECKPOINTS(CHECKPOINTS), .CHECKPOINTS_LOG(CHECKPOINTS_LOG)
      ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .pushVld  (bus.lane_valid_i[i]),
        .pushTag  (bus.lane_tag_i[i*TAG_W +: TAG_W]),
        .pushData (bus.lane_data_i[i*DATA_W +: DATA_W]),
        .pushMask (bus.lane_mask_i[i*CHECKPOINTS +: CHECKPOINTS]),
        .squash   (squash),
        .maskClr  (maskClr),
        .brId     (bus.ctrlSMTid_i),
        .pop      (grant[i]),
        .ready    (ready[i]),
        .empty    (empty[i]),
        .headVld  (headVld[i]),
        .headTag  (headTag[i]),
        .headData (headData[i])
      );
    end
  endgenerate

  // Scan lanes starting at rr; the first NUM_WR_PORTS live heads fill ports in order.
  always_comb begin
    int cnt;
    int last;
    cnt      = 0;
    last     = 0;
    grant    = '0;
    portVld  = '0;
    portTag  = '0;
    portData = '0;
    portLane = '0;
    for (int s = 0; s < NUM_LANES; s++)
      for (int l = 0; l < NUM_LANES; l++)
        if (l == (int'(rr) + s) % NUM_LANES && headVld[l] && cnt < NUM_WR_PORTS) begin
          grant[l] = 1'b1;
          for (int p = 0; p < NUM_WR_PORTS; p++)
            if (p == cnt) begin
              portVld[p]  = 1'b1;
              portTag[p]  = headTag[l];
              portData[p] = headData[l];
              portLane[p] = LANE_W'(l);
            end
          cnt++;
          last = l;
        end
    rrNxt = (cnt != 0) ? LANE_W'((last + 1) % NUM_LANES) : rr;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr      <= '0;
      wrValid <= '0;
      wrTag   <= '0;
      wrData  <= '0;
      wrLane  <= '0;
    end else begin
      rr      <= rrNxt;
      wrValid <= portVld;
      for (int p = 0; p < NUM_WR_PORTS; p++)
        if (portVld[p]) begin
          wrTag[p]  <= portTag[p];
          wrData[p] <= portData[p];
          wrLane[p] <= portLane[p];
        end
    end
  end

  assign bus.lane_ready_o = ready;
  assign bus.wr_valid_o   = wrValid;
  assign bus.wr_tag_o     = wrTag;
  assign bus.wr_data_o    = wrData;
  assign bus.wr_lane_o    = wrLane;
  assign bus.idle_o       = (&empty) & ~(|wrValid);
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: per-lane scoreboard of expected writes, a vector
// table of single-lane results, and hand sequences for fill/squash/clear/reset.
module tb_wb_port_arbiter;
  localparam int NL = 4, NP = 2, TW = 7, DW = 32, CP = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  wb_port_arbiter_if #(.NUM_LANES(NL), .NUM_WR_PORTS(NP), .DATA_W(DW), .TAG_W(TW),
                       .CHECKPOINTS(CP), .CHECKPOINTS_LOG(3)) bus();

  wb_port_arbiter #(.NUM_LANES(NL), .NUM_WR_PORTS(NP), .FIFO_DEPTH(2), .DATA_W(DW),
                    .TAG_W(TW), .CHECKPOINTS(CP), .CHECKPOINTS_LOG(3)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic [CP-1:0] mask;
  } sb_t;
  sb_t q [NL][$];

  typedef struct {
    int            lane;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic [NP-1:0] expValid;
    logic [1:0]    expLane;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic idleIn();
    bus.lane_valid_i     = '0;
    bus.lane_tag_i       = '0;
    bus.lane_data_i      = '0;
    bus.lane_mask_i      = '0;
    bus.ctrlVerified_i   = 1'b0;
    bus.ctrlMispredict_i = 1'b0;
    bus.ctrlSMTid_i      = '0;
  endtask

  task automatic offer(input int l, input logic [TW-1:0] t, input logic [DW-1:0] d,
                       input logic [CP-1:0] m);
    bus.lane_valid_i[l]         = 1'b1;
    bus.lane_tag_i[l*TW +: TW]  = t;
    bus.lane_data_i[l*DW +: DW] = d;
    bus.lane_mask_i[l*CP +: CP] = m;
  endtask

  task automatic ctrl(input logic mis, input logic [2:0] id);
    bus.ctrlVerified_i   = 1'b1;
    bus.ctrlMispredict_i = mis;
    bus.ctrlSMTid_i      = id;
  endtask

  // One clock edge; afterwards update the expected per-lane contents and check writes.
  task automatic tick();
    logic [NL-1:0]    acc;
    logic [NL*TW-1:0] tg;
    logic [NL*DW-1:0] dt;
    logic [NL*CP-1:0] mk;
    logic             sq, cl, rs;
    logic [2:0]       id;
    sb_t              e;
    sb_t              keepQ[$];
    int               ln;
    acc = bus.lane_valid_i & bus.lane_ready_o;
    tg  = bus.lane_tag_i;
    dt  = bus.lane_data_i;
    mk  = bus.lane_mask_i;
    sq  = bus.ctrlVerified_i & bus.ctrlMispredict_i;
    cl  = bus.ctrlVerified_i & ~bus.ctrlMispredict_i;
    id  = bus.ctrlSMTid_i;
    rs  = reset;
    @(posedge clk);
    #1;
    if (!rs) begin
      for (int l = 0; l < NL; l++) q[l].delete();
      chk("rst_wr_valid", bus.wr_valid_o, 0);
      return;
    end
    for (int l = 0; l < NL; l++) begin
      keepQ.delete();
      for (int k = 0; k < q[l].size(); k++) begin
        e = q[l][k];
        if (sq && e.mask[id]) continue;
        if (cl) e.mask[id] = 1'b0;
        keepQ.push_back(e);
      end
      q[l] = keepQ;
    end
    for (int p = 0; p < NP; p++)
      if (bus.wr_valid_o[p]) begin
        ln = int'(bus.wr_lane_o[p*2 +: 2]);
        if (q[ln].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: port %0d lane %0d tag %0h written, required no write",
                   p, ln, bus.wr_tag_o[p*TW +: TW]);
        end else begin
          e = q[ln].pop_front();
          chk("sb_tag", bus.wr_tag_o[p*TW +: TW], e.tag);
          chk("sb_data", bus.wr_data_o[p*DW +: DW], e.data);
        end
      end
    for (int l = 0; l < NL; l++)
      if (acc[l]) begin
        e.tag  = tg[l*TW +: TW];
        e.data = dt[l*DW +: DW];
        e.mask = mk[l*CP +: CP];
        if (sq && e.mask[id]) continue;
        if (cl) e.mask[id] = 1'b0;
        q[l].push_back(e);
      end
  endtask

  task automatic doReset();
    idleIn();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    idleIn();
    while (!bus.idle_o && n < 20) begin
      tick();
      n++;
    end
    chk("drain_idle", bus.idle_o, 1);
    for (int l = 0; l < NL; l++) chk("sb_leftover", q[l].size(), 0);
  endtask

  // Single write from lane l; leaves rr pointing at l+1.
  task automatic single(input int l, input logic [TW-1:0] t);
    idleIn();
    offer(l, t, $urandom, 8'h00);
    tick();
    drain();
  endtask

  initial begin
    vecs[0] = '{2, 7'h15, 32'hDEADBEEF, 2'b01, 2'd2};
    vecs[1] = '{3, 7'h7F, 32'hFFFFFFFF, 2'b01, 2'd3};
    vecs[2] = '{1, 7'h00, 32'h00000000, 2'b01, 2'd1};
    vecs[3] = '{2, 7'h41, 32'h12345678, 2'b01, 2'd2};
    vecs[4] = '{0, 7'h3C, 32'hA5A55A5A, 2'b01, 2'd0};

    idleIn();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    chk("rst_wr_valid_o", bus.wr_valid_o, 0);
    chk("rst_lane_ready", bus.lane_ready_o, 4'hF);
    chk("rst_idle", bus.idle_o, 1);
    chk("rst_wr_tag", bus.wr_tag_o, 0);
    chk("rst_wr_data", bus.wr_data_o, 0);
    chk("rst_wr_lane", bus.wr_lane_o, 0);

    for (int v = 0; v < 5; v++) begin
      offer(vecs[v].lane, vecs[v].tag, vecs[v].data, 8'h00);
      tick();
      idleIn();
      chk("vec_not_early", bus.wr_valid_o, 0);
      chk("vec_busy", bus.idle_o, 0);
      tick();
      chk("vec_valid", bus.wr_valid_o, vecs[v].expValid);
      chk("vec_tag", bus.wr_tag_o[TW-1:0], vecs[v].tag);
      chk("vec_data", bus.wr_data_o[DW-1:0], vecs[v].data);
      chk("vec_lane", bus.wr_lane_o[1:0], vecs[v].expLane);
      tick();
      chk("vec_idle", bus.idle_o, 1);
      chk("vec_tag_hold", bus.wr_tag_o[TW-1:0], vecs[v].tag);
    end

    // rr=1: lane 0 sits behind lanes 1,2 and fills up.
    for (int c = 0; c < 2; c++)
      for (int l = 0; l < 3; l++) offer(l, 7'(l * 16 + c), $urandom, 8'h00);
    tick();
    for (int l = 0; l < 3; l++) offer(l, 7'(l * 16 + 2), $urandom, 8'h00);
    tick();
    chk("full_ready0", bus.lane_ready_o[0], 0);
    chk("full_grant_p0", bus.wr_lane_o[1:0], 1);
    chk("full_grant_p1", bus.wr_lane_o[3:2], 2);
    idleIn();
    offer(0, 7'h6E, 32'hBAD0BAD0, 8'h00);
    tick();
    chk("grant_ready0_after", bus.lane_ready_o[0], 1);
    chk("grant_valid", bus.wr_valid_o, 2'b11);
    chk("grant_p0_lane0", bus.wr_lane_o[1:0], 0);
    chk("grant_p1_lane1", bus.wr_lane_o[3:2], 1);
    drain();

    // Squash: lane 1 holds A(mask 04), B(mask 01) behind lanes 2,3.
    doReset();
    single(1, 7'h11);
    offer(1, 7'h2A, 32'hAAAA0001, 8'h04);
    offer(2, 7'h30, $urandom, 8'h00);
    offer(3, 7'h40, $urandom, 8'h00);
    tick();
    offer(1, 7'h2B, 32'hBBBB0002, 8'h01);
    offer(2, 7'h31, $urandom, 8'h00);
    offer(3, 7'h41, $urandom, 8'h00);
    tick();
    chk("sq_pre_p0", bus.wr_lane_o[1:0], 2);
    chk("sq_pre_p1", bus.wr_lane_o[3:2], 3);
    idleIn();
    offer(3, 7'h4F, 32'hDEAD0004, 8'h04);
    ctrl(1'b1, 3'd2);
    tick();
    chk("sq_p0_lane", bus.wr_lane_o[1:0], 1);
    chk("sq_p0_tag", bus.wr_tag_o[TW-1:0], 7'h2B);
    chk("sq_p1_lane", bus.wr_lane_o[3:2], 2);
    drain();

    // Correct resolve of id 3 then mispredict of id 3: entry survives.
    doReset();
    single(0, 7'h01);
    offer(0, 7'h58, 32'hC0FFEE00, 8'h08);
    offer(1, 7'h18, $urandom, 8'h00);
    offer(2, 7'h28, $urandom, 8'h00);
    tick();
    idleIn();
    ctrl(1'b0, 3'd3);
    tick();
    idleIn();
    ctrl(1'b1, 3'd3);
    tick();
    chk("clr_valid", bus.wr_valid_o, 2'b01);
    chk("clr_lane", bus.wr_lane_o[1:0], 0);
    chk("clr_tag", bus.wr_tag_o[TW-1:0], 7'h58);
    drain();

    // All lanes streaming from rr=0: grants alternate {0,1},{2,3}.
    doReset();
    for (int c = 1; c <= 8; c++) begin
      for (int l = 0; l < NL; l++) offer(l, 7'(l * 32 + c), $urandom, 8'h00);
      tick();
      if (c >= 2) begin
        chk("rr_valid", bus.wr_valid_o, 2'b11);
        chk("rr_p0", bus.wr_lane_o[1:0], (c % 2 == 0) ? 0 : 2);
        chk("rr_p1", bus.wr_lane_o[3:2], (c % 2 == 0) ? 1 : 3);
      end
    end

    // Reset with results still buffered.
    idleIn();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_rst_valid", bus.wr_valid_o, 0);
    chk("mid_rst_ready", bus.lane_ready_o, 4'hF);
    chk("mid_rst_idle", bus.idle_o, 1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("mid_rst_no_write", bus.wr_valid_o, 0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
